// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path: default geometry, FSM encoding
// and the RGB565 field layout.
package cam_pkg;

  localparam int IMG_WIDTH_DEF   = 160;
  localparam int IMG_HEIGHT_DEF  = 120;
  localparam int BYTES_PER_PIXEL = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    CAPTURE = 2'd2
  } cap_state_e;

  localparam int RGB565_R_LSB = 11;
  localparam int RGB565_R_W   = 5;
  localparam int RGB565_G_LSB = 5;
  localparam int RGB565_G_W   = 6;
  localparam int RGB565_B_LSB = 0;
  localparam int RGB565_B_W   = 5;

  // The sensor sends R[4:0]G[5:3] first, then G[2:0]B[4:0].
  function automatic logic [15:0] rgb565_pack(input logic [7:0] hi_byte, input logic [7:0] lo_byte);
    logic [15:0] pix;
    pix = 16'h0000;
    pix[RGB565_R_LSB +: RGB565_R_W] = hi_byte[7:3];
    pix[RGB565_G_LSB +: RGB565_G_W] = {hi_byte[2:0], lo_byte[7:5]};
    pix[RGB565_B_LSB +: RGB565_B_W] = lo_byte[4:0];
    return pix;
  endfunction

endpackage

// File: rtl/cam_edge_sync.sv
// Registers the camera pins once and flags vsync/href edges against a second
// register stage; reusable by any pclk-domain camera block.
module cam_edge_sync (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       vsync_i,
  input  logic       href_i,
  input  logic [7:0] data_i,
  output logic       vsync_o,
  output logic       href_o,
  output logic [7:0] data_o,
  output logic       vsync_rise_o,
  output logic       vsync_fall_o,
  output logic       href_fall_o
);

  logic       vsync_q;
  logic       vsync_qq;
  logic       href_q;
  logic       href_qq;
  logic [7:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vsync_q  <= 1'b0;
      vsync_qq <= 1'b0;
      href_q   <= 1'b0;
      href_qq  <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      vsync_q  <= vsync_i;
      vsync_qq <= vsync_q;
      href_q   <= href_i;
      href_qq  <= href_q;
      data_q   <= data_i;
    end
  end

  assign vsync_o      = vsync_q;
  assign href_o       = href_q;
  assign data_o       = data_q;
  assign vsync_rise_o = vsync_q & ~vsync_qq;
  assign vsync_fall_o = ~vsync_q & vsync_qq;
  assign href_fall_o  = ~href_q & href_qq;

endmodule

// File: rtl/camera_capture.sv
// OV7670-style capture: pairs href bytes into RGB565 pixels and emits linear
// frame-buffer writes plus a frame-done pulse.
module camera_capture
  import cam_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int ADDR_W     = 15
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              en,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic              busy,
  output logic              line_err
);

  localparam int XW   = $clog2(IMG_WIDTH + 1);
  localparam int YW   = $clog2(IMG_HEIGHT + 1);
  localparam int PH_W = $clog2(BYTES_PER_PIXEL);

  localparam logic [XW-1:0]     X_MAX     = XW'(IMG_WIDTH);
  localparam logic [YW-1:0]     Y_MAX     = YW'(IMG_HEIGHT);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_WIDTH);

  logic        vsync_s;
  logic        href_s;
  logic [7:0]  data_s;
  logic        vsync_rise_s;
  logic        vsync_fall_s;
  logic        href_fall_s;

  cap_state_e        state_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [ADDR_W-1:0] base_q;
  logic [PH_W-1:0]   phase_q;
  logic [7:0]        hi_q;
  logic              pend_v_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [15:0]       pend_data_q;
  logic              frame_done_q;
  logic              busy_q;
  logic              line_err_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [15:0]       wr_data_q;

  logic [ADDR_W-1:0] pix_addr_d;
  logic [15:0]       pix_data_d;
  logic              in_bounds_d;

  cam_edge_sync u_edge_sync (
    .clk_i        (pclk),
    .rst_i        (rst),
    .vsync_i      (vsync),
    .href_i       (href),
    .data_i       (data),
    .vsync_o      (vsync_s),
    .href_o       (href_s),
    .data_o       (data_s),
    .vsync_rise_o (vsync_rise_s),
    .vsync_fall_o (vsync_fall_s),
    .href_fall_o  (href_fall_s)
  );

  // Line base advances by IMG_WIDTH per line, so the address needs only an adder.
  assign pix_addr_d  = base_q + ADDR_W'(x_q);
  assign pix_data_d  = rgb565_pack(hi_q, data_s);
  assign in_bounds_d = (x_q < X_MAX) && (y_q < Y_MAX);

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      base_q       <= '0;
      phase_q      <= '0;
      hi_q         <= 8'h00;
      pend_v_q     <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= 16'h0000;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      line_err_q   <= 1'b0;
    end else begin
      pend_v_q     <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (en && vsync_s) begin
            state_q <= SYNC;
          end
        end
        SYNC: begin
          if (!en) begin
            state_q <= IDLE;
          end else if (vsync_fall_s) begin
            state_q    <= CAPTURE;
            busy_q     <= 1'b1;
            x_q        <= '0;
            y_q        <= '0;
            base_q     <= '0;
            phase_q    <= '0;
            line_err_q <= 1'b0;
          end
        end
        CAPTURE: begin
          if (href_s) begin
            if (phase_q == PH_W'(0)) begin
              hi_q    <= data_s;
              phase_q <= PH_W'(1);
            end else begin
              phase_q <= PH_W'(0);
              if (in_bounds_d) begin
                pend_v_q    <= 1'b1;
                pend_addr_q <= pix_addr_d;
                pend_data_q <= pix_data_d;
                x_q         <= x_q + XW'(1);
              end else begin
                line_err_q <= 1'b1;
              end
            end
          end else if (href_fall_s) begin
            // Odd trailing byte or short line marks the frame as malformed.
            if ((phase_q != PH_W'(0)) || (x_q != X_MAX)) begin
              line_err_q <= 1'b1;
            end
            phase_q <= PH_W'(0);
            x_q     <= '0;
            if ((x_q != '0) && (y_q < Y_MAX)) begin
              y_q    <= y_q + YW'(1);
              base_q <= base_q + LINE_STEP;
            end
          end
          if (vsync_rise_s) begin
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= en ? SYNC : IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Output register; address and data hold between strobes.
  always_ff @(posedge pclk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 16'h0000;
    end else begin
      wr_en_q <= pend_v_q;
      if (pend_v_q) begin
        wr_addr_q <= pend_addr_q;
        wr_data_q <= pend_data_q;
      end
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign line_err   = line_err_q;

endmodule
